// File: rtl/serial_subtractor8_if.sv
// Valid/ready operand and result bundle for serial_subtractor8.
// The slave modport is the subtractor's view and the master modport is the producer/consumer view.
interface serial_subtractor8_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport slave (
        input  in_valid,
        input  minuend,
        input  subtrahend,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output borrow,
        output ovf
    );

    modport master (
        output in_valid,
        output minuend,
        output subtrahend,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  borrow,
        input  ovf
    );
endinterface

// File: rtl/serial_subtractor8.sv
// Bit-serial unsigned subtractor that computes one full-subtractor bit per clock, with valid/ready on both sides.
// Optional signed-overflow flag: define SERIAL_SUB_SIGNED_OVF_EN; otherwise ovf is tied to 0.
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor8_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt;
    logic             br_q;
    logic             borrow_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic bit_a;
    logic bit_b;
    logic bit_d;
    logic br_next;
    logic accept;
    logic last_bit;

    always_comb begin
        bit_a    = sh_a[0];
        bit_b    = sh_b[0];
        bit_d    = bit_a ^ bit_b ^ br_q;
        br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        accept   = (state == IDLE) && bus.in_valid;
        last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh_a        <= '0;
            sh_b        <= '0;
            res         <= '0;
            diff_q      <= '0;
            cnt         <= '0;
            br_q        <= 1'b0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_a       <= bus.minuend;
                        sh_b       <= bus.subtrahend;
                        br_q       <= 1'b0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Result fills from the MSB so bit 0 lands in res[0] after WIDTH shifts.
                    res  <= {bit_d, res[WIDTH-1:1]};
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    br_q <= br_next;
                    if (last_bit) begin
                        diff_q      <= {bit_d, res[WIDTH-1:1]};
                        borrow_q    <= br_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic sign_a;
    logic sign_b;
    logic ovf_q;

    // Two's-complement overflow: operands of differing sign whose result sign differs from the minuend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            sign_a <= bus.minuend[WIDTH-1];
            sign_b <= bus.subtrahend[WIDTH-1];
        end else if (last_bit) begin
            ovf_q <= (sign_a != sign_b) && (bit_d != sign_a);
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
endmodule

// File: doc/serial_subtractor8.md
Name: serial_subtractor8

Overview:
- Bit-serial unsigned subtractor: the inverse of the team's 8-bit carry-select adder. Given a sum and one addend, it recovers the other addend (diff = minuend - subtrahend) plus a borrow flag.
- Processes one bit per clock through a single full-subtractor cell, trading latency for area in small tiles.
- Valid/ready handshake on both input and output so it can sit behind the adder datapath or a pin-level loader.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- minuend  input  WIDTH  operand A (the sum)
- subtrahend  input  WIDTH  operand B (the known addend)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (minuend - subtrahend) mod 2^WIDTH
- borrow  output  1  1 when minuend < subtrahend (unsigned)
- ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; diff=0; borrow=0; ovf=0; internal shift registers, bit counter and borrow register cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an in_valid & in_ready edge: load minuend into shift register A and subtrahend into shift register B, clear the borrow register and counter, then go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge takes a=A[0], b=B[0], br=borrow register, and computes d = a^b^br and br_next = (~a & b) | (~(a^b) & br).
  - d shifts into the MSB of the result register, which shifts right. A and B shift right. The borrow register takes br_next and the counter increments.
  - When counter == WIDTH-1, that edge completes the last bit and the state goes to DONE.
  - The counter is $clog2(WIDTH+1) bits wide and never wraps.
- DONE:
  - out_valid=1.
  - diff = result register; borrow = final borrow register.
  - diff, borrow and ovf are held stable until an out_valid & out_ready edge, after which the state returns to IDLE.
- Latency: WIDTH+1 edges from the accept edge to the first cycle with out_valid high. Throughput is one operation per WIDTH+2 cycles minimum.
- diff and borrow update only on the RUN→DONE edge. They keep their old values during IDLE and RUN.
- in_valid outside IDLE is ignored. The upstream holds operands until in_ready is observed; operand changes during RUN have no effect.
- out_ready outside DONE is ignored. If out_ready is already high on DONE entry, the handshake completes in the first DONE cycle.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. Outputs return to reset values and no result is emitted.
- Operands are unsigned. Equal operands give diff=0, borrow=0.

Optional Feature:
- Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - Captures the sign bits of minuend and subtrahend at accept.
  - On RUN→DONE, ovf = (sA != sB) & (diff[WIDTH-1] != sA), i.e. two's-complement overflow of A-B.
  - ovf is held with diff and cleared by reset.
- Undefined: the ovf port still exists and is tied to 0. No extra registers are built.

Test Plan:
- Basic subtract: minuend=0xC8, subtrahend=0x37, in_valid=1, out_ready=1 → out_valid high exactly 9 edges after accept; diff=0x91, borrow=0.
- Underflow: 0x05 - 0x0A → diff=0xFB, borrow=1. Also 0x00 - 0xFF → diff=0x01, borrow=1.
- Equal operands, and round-trip against the adder:
  - 0x5A - 0x5A → diff=0x00, borrow=0.
  - Adder sum of 0x3C+0x4D (0x89) minus 0x3C → diff=0x4D, borrow=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid, diff and borrow stay stable and in_ready stays 0; a second in_valid pulse in this window is ignored.
  - Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-op: assert rst_n=0 four edges into RUN → in_ready=1 and out_valid=0 immediately (async); after release a fresh 0x10-0x01 gives diff=0x0F, borrow=0.
- With SERIAL_SUB_SIGNED_OVF_EN:
  - 0x80 - 0x01 → diff=0x7F, borrow=0, ovf=1.
  - 0x7F - 0xFF → diff=0x80, borrow=1, ovf=1.
  - 0x10 - 0x20 → ovf=0.
  - Without the macro, ovf=0 in all cases.
